// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Imported by the receiver and any future UART blocks.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Latency: 2 clk. No backpressure; RST_VAL is the value held through reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) into a one-entry valid/ready holding register.
// Latency: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk from rx_i falling to rx_valid_o (+CLKS_PER_BIT with parity).
// Backpressure: a byte completing while the holding register is full and not consumed is dropped and overrun_o pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic                      busy_o,
    output logic                      frame_err_o,
    output logic                      parity_err_o,
    output logic                      overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      ferr_q;
    logic                      ovr_q;
    logic                      rx_s;
    logic                      cnt_clr;
    logic                      cnt_done;
    logic                      sample_data;
    logic                      commit;
    logic                      ferr_set;
    logic                      consume;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    assign cnt_done = (cnt_q == CNT_BIT);
    assign consume  = valid_q && rx_ready_i;

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic par_sample;
    logic perr_set;
    logic perr_q;
    logic par_bad;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{shift_q, par_q};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        sample_data = 1'b0;
        commit      = 1'b0;
        ferr_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample  = 1'b0;
        perr_set    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_clr     = 1'b1;
                    sample_data = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_done) begin
                    cnt_clr    = 1'b1;
                    par_sample = 1'b1;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_done) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad) begin
                        perr_set = 1'b1;
                        state_d  = IDLE;
                    end
`endif
                    else begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_clr = 1'b1;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + CW'(1);
            if (state_q != DATA)  bit_idx_q <= '0;
            else if (sample_data) bit_idx_q <= bit_idx_q + 3'd1;
            if (sample_data) shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            ferr_q <= ferr_set;
            ovr_q  <= commit && valid_q && !rx_ready_i;
            // A commit wins over a simultaneous consume so the register stays full.
            if (commit && (!valid_q || rx_ready_i)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (par_sample) par_q <= rx_s;
            perr_q <= perr_set;
        end
    end

    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; works with or without UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + C/2 + 9*C + 1 + C;
`else
    localparam int LAT = 2 + C/2 + 9*C + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       busy_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorders, sampled on the falling edge.
    logic [7:0] got[$];
    int   vr = 0, run = 0, last_run = 0, rise_cyc = 0;
    int   fe_cyc = 0, pe_cyc = 0, ov_cyc = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
            if (rx_valid_o && !prev_valid) begin
                vr++;
                rise_cyc = cyc;
            end
            if (rx_valid_o) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (frame_err_o)  fe_cyc++;
            if (parity_err_o) pe_cyc++;
            if (overrun_o)    ov_cyc++;
            prev_valid = rx_valid_o;
        end else begin
            prev_valid = 1'b0;
            run = 0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int start_cyc = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (C) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the line at the stop-bit level when done.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop);
    endtask

    int exp_perr = 0;
    int vr0, fe0, n0;
    int waited;

    initial begin
        rst        = 1'b1;
        rx_i       = 1'b1;
        rx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  rx_data_o,    8'h00);
        chk("rst_valid", rx_valid_o,   0);
        chk("rst_busy",  busy_o,       0);
        chk("rst_ferr",  frame_err_o,  0);
        chk("rst_perr",  parity_err_o, 0);
        chk("rst_ovr",   overrun_o,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // Single byte, exact latency, one-cycle valid with ready held high.
        send_frame(8'h55, 1'b1);
        idle(4);
        chk("b55_count",   got.size(), 1);
        chk("b55_data",    got[0], 8'h55);
        chk("b55_latency", rise_cyc - start_cyc, LAT);
        chk("b55_vlen",    last_run, 1);

        // One-bit idle gap, then two frames with no gap.
        send_frame(8'hA3, 1'b1);
        idle(C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(4);
        chk("b2b_count", got.size(), 5);
        chk("b2b_d1", got[1], 8'hA3);
        chk("b2b_d2", got[2], 8'h3C);
        chk("b2b_d3", got[3], 8'hA3);
        chk("b2b_d4", got[4], 8'h3C);
        chk("b2b_ferr", fe_cyc, 0);

        // Overrun: second byte dropped while the register is full.
        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(C);
        send_frame(8'h22, 1'b1);
        idle(4);
        chk("ovr_valid", rx_valid_o, 1);
        chk("ovr_data",  rx_data_o, 8'h11);
        chk("ovr_pulse", ov_cyc, 1);
        // Ready is high only in the cycle whose edge commits 0x33.
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                rx_ready_i = 1'b1;
                @(posedge clk);
                #1;
                rx_ready_i = 1'b0;
            end
        join
        idle(2);
        chk("sim_count", got.size(), 6);
        chk("sim_old",   got[5], 8'h11);
        chk("sim_data",  rx_data_o, 8'h33);
        chk("sim_valid", rx_valid_o, 1);
        chk("sim_noovr", ov_cyc, 1);
        rx_ready_i = 1'b1;
        idle(2);
        chk("drain_count", got.size(), 7);
        chk("drain_data",  got[6], 8'h33);

        // Framing error followed by a held-low line.
        vr0 = vr;
        send_frame(8'h7E, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(C);
        chk("fe_pulse", fe_cyc, 1);
        chk("fe_novld", vr, vr0);
        send_frame(8'h42, 1'b1);
        idle(4);
        chk("fe_next_count", got.size(), 8);
        chk("fe_next_data",  got[7], 8'h42);
        chk("fe_once", fe_cyc, 1);

        // Short low glitch on the line.
        vr0 = vr;
        rx_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rx_i = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (busy_o && waited < 12);
        chk("glitch_busy", busy_o, 0);
        idle(LAT);
        chk("glitch_novld", vr, vr0);
        chk("glitch_nofe",  fe_cyc, 1);

        // Reset mid-frame.
        vr0 = vr;
        fe0 = fe_cyc;
        n0  = got.size();
        rx_i = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst  = 1'b1;
        rx_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_data",  rx_data_o, 8'h00);
        chk("mrst_valid", rx_valid_o, 0);
        chk("mrst_busy",  busy_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2 * C);
        chk("mrst_novld", vr, vr0);
        chk("mrst_nofe",  fe_cyc, fe0);
        send_frame(8'h5A, 1'b1);
        idle(4);
        chk("mrst_next_count", got.size(), n0 + 1);
        chk("mrst_next_data",  got[n0], 8'h5A);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity requires a 1.
        n0 = got.size();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(4);
        chk("par_ok_count", got.size(), n0 + 1);
        chk("par_ok_data",  got[n0], 8'h07);
        vr0 = vr;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(4);
        par_flip = 1'b0;
        exp_perr = 1;
        chk("par_bad_novld", vr, vr0);
`endif
        chk("perr_pulses", pe_cyc, exp_perr);
        chk("final_ovr",   ov_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
